status_display_driver: RTL and testbench
========================================

# status_display_driver

Downstream stage of the push-button status path: consumes the 3-bit status code from the state detector and the debounced sound request, and drives the 4-digit multiplexed common-anode 7-segment display and the piezo buzzer. Each status code is rendered as a fixed 4-character word. The error word blinks. Any status change produces a short buzzer chirp, and a held sound request produces a continuous beep pattern.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; 1 kHz digit rate at 50 MHz.
- BLINK_DIV, 12500000: clock cycles per blink half-period for the error word.
- BEEP_ON, 5000000: buzzer-high cycles per beep period.
- BEEP_OFF, 5000000: buzzer-low cycles per beep period.
- CHIRP_LEN, 2500000: buzzer-high cycles on a status change.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- state  in  3  status code: 0 idle, 1 err, 2 off, 3 on, 4 open, 5–7 undefined.
- buzz  in  1  debounced sound request, level.
- digit  out  4  digit enables, active-low; digit[3] is the leftmost digit.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- buzzer  out  1  buzzer drive, active-high.

## Operation
- Input capture: `state` and `buzz` are registered every clock into state_q and buzz_q. state_prev holds the previous state_q.
- Word selected by state_q (digits left to right):
  - 0: "----"
  - 1: "Err " (blinking)
  - 2: "OFF "
  - 3: "On  "
  - 4: "OPEn"
  - 5–7: blank
- Glyph codes (active-low):
  - '-' = 8'hBF, 'E' = 8'h86, 'r' = 8'hAF, 'O' = 8'hC0, 'F' = 8'h8E, 'n' = 8'hAB, 'P' = 8'h8C
  - blank = 8'hFF; dp is always off.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - At terminal count, the 2-bit slot index advances 0→1→2→3→0; slot 0 is digit[3], slot 3 is digit[0].
  - `digit` and `seg` are registered and update only on that edge. Exactly one `digit` bit is low after the first advance.
- Blink:
  - blink_cnt wraps at BLINK_DIV-1 and toggles blink_phase.
  - When state_q==1 and blink_phase==1, `seg` is forced to 8'hFF; `digit` keeps scanning.
  - blink_cnt and blink_phase keep running regardless of state.
- Chirp:
  - state_q != state_prev loads chirp_cnt = CHIRP_LEN.
  - A new change during a chirp reloads the count (restart, not extend).
- Beep:
  - While buzz_q=1, beep_cnt cycles through BEEP_ON high cycles followed by BEEP_OFF low cycles.
  - buzz_q=0 clears beep_cnt, so the next request starts in the high phase.
- buzzer = (chirp_cnt != 0) | (buzz_q & beep_high), registered.

## Timing
- Reset values:
  - digit = 4'b1111, seg = 8'hFF, buzzer = 0.
  - All counters 0, slot index 0, blink_phase 0.
  - state_q = state_prev = 0, buzz_q = 0.
- Reset release with `state` ≠ 0 produces one chirp. Reset asserted mid-chirp or mid-beep returns all outputs to reset values immediately.
- `state` change → state_q after 1 clk; buzzer high 2 clks after the `state` edge; high for exactly CHIRP_LEN clks.
- `state` change → new glyph on `seg` at the next slot advance after state_q updates (worst case SCAN_DIV+1 clks).
- `buzz` rise → buzzer high after 2 clks. `buzz` fall → buzzer low after 2 clks unless a chirp is active.
- First digit enable asserts SCAN_DIV clks after reset release.

## Structure
- Shared package `display_pkg`:
  - state code localparams (ST_IDLE..ST_OPEN)
  - glyph constants (GLYPH_DASH, GLYPH_E, ..., GLYPH_BLANK)
- Sub-module `seg_glyph_lut`: combinational map (state code, slot index) → active-low segment byte. Top-level holds all counters and output registers.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_DIV=16, BEEP_ON=8, BEEP_OFF=8, CHIRP_LEN=5.
- Reset with state=0, buzz=0, then release:
  - digit=1111, seg=FF, buzzer=0 until clk 4.
  - Then digit cycles 0111→1011→1101→1110 every 4 clks with seg=BF each slot; buzzer stays 0.
- state 0→4 held: buzzer high for exactly 5 clks starting 2 clks after the change; from the next slot, seg sequence is 8C? no — slot sequence is C0, 8C, 86, AB ("OPEn").
- state=1 held: seg alternates between the "Err " pattern (86, AF, AF, FF) for 16 clks and FF for 16 clks.
- buzz held high 40 clks: buzzer pattern is 8 high / 8 low / 8 high / 8 low / 8 high; buzzer drops 2 clks after buzz falls.
- state 2→3 then 3→2 spaced 3 clks apart: chirp restarts, so buzzer is high continuously for 3+5 = 8 clks.
- reset asserted during a chirp and a beep with state=5: all outputs return to reset values asynchronously; after release, one 5-clk chirp, then blank (FF) on all slots.

Source files
------------

// File: rtl/display_pkg.sv
// Shared status codes and active-low 7-segment glyphs for the status display path.
package display_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ERR  = 3'd1;
    localparam logic [2:0] ST_OFF  = 3'd2;
    localparam logic [2:0] ST_ON   = 3'd3;
    localparam logic [2:0] ST_OPEN = 3'd4;

    // Segment order {dp,g,f,e,d,c,b,a}, low = lit; dp is never lit.
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;
    localparam logic [7:0] GLYPH_E     = 8'h86;
    localparam logic [7:0] GLYPH_R     = 8'hAF;
    localparam logic [7:0] GLYPH_O     = 8'hC0;
    localparam logic [7:0] GLYPH_F     = 8'h8E;
    localparam logic [7:0] GLYPH_N     = 8'hAB;
    localparam logic [7:0] GLYPH_P     = 8'h8C;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    typedef logic [1:0] slot_t;

    // Slot 0 is the leftmost digit (digit[3]); enables are active-low.
    function automatic logic [3:0] slot_enable(input slot_t slot);
        return ~(4'b1000 >> slot);
    endfunction

endpackage

// File: rtl/seg_glyph_lut.sv
// Maps a status code and digit slot to the active-low segment byte of that word's character.
module seg_glyph_lut
    import display_pkg::*;
(
    input  logic [2:0] i_state,
    input  slot_t      i_slot,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = GLYPH_BLANK;
        case (i_state)
            ST_IDLE: o_seg = GLYPH_DASH;
            ST_ERR: begin
                case (i_slot)
                    2'd0:       o_seg = GLYPH_E;
                    2'd1, 2'd2: o_seg = GLYPH_R;
                    default:    o_seg = GLYPH_BLANK;
                endcase
            end
            ST_OFF: begin
                case (i_slot)
                    2'd0:       o_seg = GLYPH_O;
                    2'd1, 2'd2: o_seg = GLYPH_F;
                    default:    o_seg = GLYPH_BLANK;
                endcase
            end
            ST_ON: begin
                case (i_slot)
                    2'd0:    o_seg = GLYPH_O;
                    2'd1:    o_seg = GLYPH_N;
                    default: o_seg = GLYPH_BLANK;
                endcase
            end
            ST_OPEN: begin
                case (i_slot)
                    2'd0:    o_seg = GLYPH_O;
                    2'd1:    o_seg = GLYPH_P;
                    2'd2:    o_seg = GLYPH_E;
                    default: o_seg = GLYPH_N;
                endcase
            end
            default: o_seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/status_display_driver.sv
// Drives the 4-digit multiplexed display and piezo buzzer from the status code and sound request.
module status_display_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000,
    parameter int BEEP_ON   = 5000000,
    parameter int BEEP_OFF  = 5000000,
    parameter int CHIRP_LEN = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       buzz,
    output logic [3:0] digit,
    output logic [7:0] seg,
    output logic       buzzer
);

    localparam int BEEP_PERIOD = BEEP_ON + BEEP_OFF;
    localparam int SCAN_W  = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
    localparam int BLINK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;
    localparam int BEEP_W  = (BEEP_PERIOD > 1) ? $clog2(BEEP_PERIOD) : 1;
    localparam int CHIRP_W = $clog2(CHIRP_LEN + 1);

    logic [2:0]         r_state_q;
    logic [2:0]         r_state_prev;
    logic               r_buzz_q;
    logic [SCAN_W-1:0]  r_scan_cnt;
    slot_t              r_slot;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [CHIRP_W-1:0] r_chirp_cnt;
    logic [BEEP_W-1:0]  r_beep_cnt;
    logic [3:0]         r_digit;
    logic [7:0]         r_seg;
    logic               r_buzzer;

    logic               w_scan_tc;
    logic               w_blink_tc;
    logic               w_beep_wrap;
    logic               w_beep_high;
    logic               w_state_change;
    logic [7:0]         w_glyph;
    logic [7:0]         w_seg_next;
    logic [CHIRP_W-1:0] w_chirp_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q    <= ST_IDLE;
            r_state_prev <= ST_IDLE;
            r_buzz_q     <= 1'b0;
        end else begin
            r_state_q    <= state;
            r_state_prev <= r_state_q;
            r_buzz_q     <= buzz;
        end
    end

    assign w_scan_tc   = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign w_blink_tc  = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
    assign w_beep_wrap = (r_beep_cnt == BEEP_W'(BEEP_PERIOD - 1));
    assign w_beep_high = (r_beep_cnt < BEEP_W'(BEEP_ON));
    assign w_state_change = (r_state_q != r_state_prev);

    seg_glyph_lut u_glyph_lut (
        .i_state (r_state_q),
        .i_slot  (r_slot),
        .o_seg   (w_glyph)
    );

    assign w_seg_next = ((r_state_q == ST_ERR) && r_blink_phase) ? GLYPH_BLANK : w_glyph;

    // A fresh change reloads the full length, so back-to-back changes restart the chirp.
    always_comb begin
        w_chirp_next = r_chirp_cnt;
        if (w_state_change) begin
            w_chirp_next = CHIRP_W'(CHIRP_LEN);
        end else if (r_chirp_cnt != '0) begin
            w_chirp_next = r_chirp_cnt - CHIRP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt    <= '0;
            r_slot        <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_chirp_cnt   <= '0;
            r_beep_cnt    <= '0;
        end else begin
            r_scan_cnt  <= w_scan_tc ? '0 : r_scan_cnt + SCAN_W'(1);
            if (w_scan_tc) begin
                r_slot <= r_slot + 2'd1;
            end
            r_blink_cnt <= w_blink_tc ? '0 : r_blink_cnt + BLINK_W'(1);
            if (w_blink_tc) begin
                r_blink_phase <= ~r_blink_phase;
            end
            r_chirp_cnt <= w_chirp_next;
            if (!r_buzz_q || w_beep_wrap) begin
                r_beep_cnt <= '0;
            end else begin
                r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
            end
        end
    end

    // The chirp term looks at the count being loaded so a status change and a buzz
    // request both reach the buzzer 2 clks after their input edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit  <= 4'b1111;
            r_seg    <= GLYPH_BLANK;
            r_buzzer <= 1'b0;
        end else begin
            if (w_scan_tc) begin
                r_digit <= slot_enable(r_slot);
                r_seg   <= w_seg_next;
            end
            r_buzzer <= (w_chirp_next != '0) | (r_buzz_q & w_beep_high);
        end
    end

    assign digit  = r_digit;
    assign seg    = r_seg;
    assign buzzer = r_buzzer;

endmodule

// File: tb/tb_status_display_driver.sv
// Scenario bench for status_display_driver with short scan, blink, beep and chirp periods.
module tb_status_display_driver;

    typedef struct {
        logic [3:0] dig;
        logic [7:0] seg;
        logic       bz;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [2:0] state;
    logic       buzz;
    logic [3:0] digit;
    logic [7:0] seg;
    logic       buzzer;

    int   total;
    int   bad;
    int   cyc;
    exp_t sb[$];
    logic [3:0] cur_dig;
    logic [7:0] cur_seg;

    status_display_driver #(
        .SCAN_DIV  (4),
        .BLINK_DIV (16),
        .BEEP_ON   (8),
        .BEEP_OFF  (8),
        .CHIRP_LEN (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .state  (state),
        .buzz   (buzz),
        .digit  (digit),
        .seg    (seg),
        .buzzer (buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] dig_of(input int slot);
        case (slot)
            0:       return 4'b0111;
            1:       return 4'b1011;
            2:       return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int st, input int slot, input int ph);
        logic [7:0] w[4];
        case (st)
            0:       w = '{8'hBF, 8'hBF, 8'hBF, 8'hBF};
            1:       w = '{8'h86, 8'hAF, 8'hAF, 8'hFF};
            2:       w = '{8'hC0, 8'h8E, 8'h8E, 8'hFF};
            3:       w = '{8'hC0, 8'hAB, 8'hFF, 8'hFF};
            4:       w = '{8'hC0, 8'h8C, 8'h86, 8'hAB};
            default: w = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        endcase
        if (st == 1 && ph == 1) return 8'hFF;
        return w[slot];
    endfunction

    // Expected outputs after edge n; sq is the registered status seen just before that edge.
    task automatic push_exp(input int n, input int sq, input logic bz);
        exp_t e;
        int   s;
        if (n % 4 == 0) begin
            s = (n / 4 - 1) % 4;
            cur_dig = dig_of(s);
            cur_seg = exp_seg(sq, s, ((n - 1) / 16) % 2);
        end
        e.dig = cur_dig;
        e.seg = cur_seg;
        e.bz  = bz;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset(input logic [2:0] st, input logic bz);
        @(negedge clk);
        reset = 1'b0;
        state = st;
        buzz  = bz;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        cur_dig = 4'hF;
        cur_seg = 8'hFF;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        state = 3'd0;
        buzz  = 1'b0;
        #2;
        total++; if (digit !== 4'hF) begin bad++; $display("FAIL reset_in digit got=%b want=1111", digit); end
        total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_in seg got=%h want=ff", seg); end
        total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL reset_in buzzer got=%b want=0", buzzer); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        cur_dig = 4'hF;
        cur_seg = 8'hFF;
        sb.delete();
        for (int n = 1; n <= 20; n++) push_exp(n, 0, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            e = sb.pop_front();
            total++; if (digit !== e.dig) begin bad++; $display("FAIL reset digit cyc=%0d got=%b want=%b", cyc, digit, e.dig); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL reset seg cyc=%0d got=%h want=%h", cyc, seg, e.seg); end
            total++; if (buzzer !== e.bz) begin bad++; $display("FAIL reset buzzer cyc=%0d got=%b want=%b", cyc, buzzer, e.bz); end
        end
        $display("scenario reset: 20 cycles checked");
    endtask

    task automatic test_open();
        exp_t e;
        apply_reset(3'd0, 1'b0);
        for (int n = 1; n <= 24; n++) push_exp(n, (n >= 4) ? 4 : 0, (n >= 4 && n <= 8));
        for (int n = 1; n <= 24; n++) begin
            tick();
            e = sb.pop_front();
            total++; if (digit !== e.dig) begin bad++; $display("FAIL open digit cyc=%0d got=%b want=%b", cyc, digit, e.dig); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL open seg cyc=%0d got=%h want=%h", cyc, seg, e.seg); end
            total++; if (buzzer !== e.bz) begin bad++; $display("FAIL open buzzer cyc=%0d got=%b want=%b", cyc, buzzer, e.bz); end
            if (cyc == 2) state = 3'd4;
        end
        $display("scenario open: 24 cycles checked");
    endtask

    task automatic test_blink();
        exp_t e;
        apply_reset(3'd1, 1'b0);
        for (int n = 1; n <= 52; n++) push_exp(n, 1, (n >= 2 && n <= 6));
        for (int n = 1; n <= 52; n++) begin
            tick();
            e = sb.pop_front();
            total++; if (digit !== e.dig) begin bad++; $display("FAIL blink digit cyc=%0d got=%b want=%b", cyc, digit, e.dig); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL blink seg cyc=%0d got=%h want=%h", cyc, seg, e.seg); end
            total++; if (buzzer !== e.bz) begin bad++; $display("FAIL blink buzzer cyc=%0d got=%b want=%b", cyc, buzzer, e.bz); end
        end
        $display("scenario blink: 52 cycles checked");
    endtask

    task automatic test_beep();
        exp_t e;
        apply_reset(3'd0, 1'b0);
        for (int n = 1; n <= 50; n++) push_exp(n, 0, (n >= 4 && n <= 43 && ((n - 4) % 16) < 8));
        for (int n = 1; n <= 50; n++) begin
            tick();
            e = sb.pop_front();
            total++; if (digit !== e.dig) begin bad++; $display("FAIL beep digit cyc=%0d got=%b want=%b", cyc, digit, e.dig); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL beep seg cyc=%0d got=%h want=%h", cyc, seg, e.seg); end
            total++; if (buzzer !== e.bz) begin bad++; $display("FAIL beep buzzer cyc=%0d got=%b want=%b", cyc, buzzer, e.bz); end
            if (cyc == 2)  buzz = 1'b1;
            if (cyc == 42) buzz = 1'b0;
        end
        $display("scenario beep: 50 cycles checked");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset(3'd2, 1'b0);
        for (int n = 1; n <= 28; n++)
            push_exp(n, (n >= 12 && n <= 14) ? 3 : 2, ((n >= 2 && n <= 6) || (n >= 12 && n <= 19)));
        for (int n = 1; n <= 28; n++) begin
            tick();
            e = sb.pop_front();
            total++; if (digit !== e.dig) begin bad++; $display("FAIL b2b digit cyc=%0d got=%b want=%b", cyc, digit, e.dig); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL b2b seg cyc=%0d got=%h want=%h", cyc, seg, e.seg); end
            total++; if (buzzer !== e.bz) begin bad++; $display("FAIL b2b buzzer cyc=%0d got=%b want=%b", cyc, buzzer, e.bz); end
            if (cyc == 10) state = 3'd3;
            if (cyc == 13) state = 3'd2;
        end
        $display("scenario back_to_back: 28 cycles checked");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        apply_reset(3'd0, 1'b0);
        for (int n = 1; n <= 6; n++) push_exp(n, (n >= 4) ? 5 : 0, (n >= 4));
        for (int n = 1; n <= 6; n++) begin
            tick();
            e = sb.pop_front();
            total++; if (digit !== e.dig) begin bad++; $display("FAIL mid_pre digit cyc=%0d got=%b want=%b", cyc, digit, e.dig); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL mid_pre seg cyc=%0d got=%h want=%h", cyc, seg, e.seg); end
            total++; if (buzzer !== e.bz) begin bad++; $display("FAIL mid_pre buzzer cyc=%0d got=%b want=%b", cyc, buzzer, e.bz); end
            if (cyc == 2) begin
                state = 3'd5;
                buzz  = 1'b1;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        total++; if (digit !== 4'hF) begin bad++; $display("FAIL mid_async digit got=%b want=1111", digit); end
        total++; if (seg !== 8'hFF) begin bad++; $display("FAIL mid_async seg got=%h want=ff", seg); end
        total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL mid_async buzzer got=%b want=0", buzzer); end
        buzz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        cur_dig = 4'hF;
        cur_seg = 8'hFF;
        sb.delete();
        for (int n = 1; n <= 20; n++) push_exp(n, 5, (n >= 2 && n <= 6));
        for (int n = 1; n <= 20; n++) begin
            tick();
            e = sb.pop_front();
            total++; if (digit !== e.dig) begin bad++; $display("FAIL mid_post digit cyc=%0d got=%b want=%b", cyc, digit, e.dig); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL mid_post seg cyc=%0d got=%h want=%h", cyc, seg, e.seg); end
            total++; if (buzzer !== e.bz) begin bad++; $display("FAIL mid_post buzzer cyc=%0d got=%b want=%b", cyc, buzzer, e.bz); end
        end
        $display("scenario reset_mid: 26 cycles checked");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b0;
        state = 3'd0;
        buzz  = 1'b0;
        cur_dig = 4'hF;
        cur_seg = 8'hFF;
        test_reset();
        test_open();
        test_blink();
        test_beep();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
